// File: rtl/lu_pkg.sv
// Shared constants, state encoding and small helpers for the logic-unit
// op identifier and its reference model.
package lu_pkg;

    localparam logic [1:0] OP_NAND = 2'b00;
    localparam logic [1:0] OP_AND  = 2'b01;
    localparam logic [1:0] OP_NOR  = 2'b10;
    localparam logic [1:0] OP_OR   = 2'b11;

    localparam logic ERR_CONTRA = 1'b0;
    localparam logic ERR_AMBIG  = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'b00,
        ST_COLLECT = 2'b01,
        ST_DONE    = 2'b10,
        ST_ERROR   = 2'b11
    } state_t;

    function automatic logic [2:0] popcount4(input logic [3:0] v);
        logic [2:0] n;
        n = 3'd0;
        for (int i = 0; i < 4; i++) begin
            n = n + {2'b00, v[i]};
        end
        return n;
    endfunction

    // Only meaningful for one-hot inputs; anything else maps to 0.
    function automatic logic [1:0] onehot_index4(input logic [3:0] v);
        logic [1:0] idx;
        case (v)
            4'b0001: idx = 2'd0;
            4'b0010: idx = 2'd1;
            4'b0100: idx = 2'd2;
            4'b1000: idx = 2'd3;
            default: idx = 2'd0;
        endcase
        return idx;
    endfunction

endpackage

// File: rtl/lu_ref_model.sv
// Combinational model of the 2-input logic unit: predicted output of each
// op code for the given operands, bit i is op code i.
module lu_ref_model (
    input  logic       a,
    input  logic       b,
    output logic [3:0] p
);
    assign p = {a | b, ~(a | b), a & b, ~(a & b)};
endmodule

// File: rtl/lu_op_identifier.sv
// Recovers which logic-unit op produced a stream of observed (a, b, s_obs)
// samples by eliminating candidates whose prediction disagrees.
module lu_op_identifier
    import lu_pkg::*;
#(
    parameter int MAX_SAMPLES = 8,
    parameter int CNT_W       = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             a,
    input  logic             b,
    input  logic             s_obs,
    output logic             busy,
    output logic             id_valid,
    output logic [1:0]       id_op,
    output logic             id_error,
    output logic             err_kind,
    output logic [3:0]       cand_mask,
    output logic [CNT_W-1:0] sample_count
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_SAMPLES);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    state_t           state_r, state_nxt;
    logic [3:0]       mask_r, mask_nxt;
    logic [CNT_W-1:0] cnt_r, cnt_nxt;
    logic [1:0]       op_r, op_nxt;
    logic             valid_r, valid_nxt;
    logic             error_r, error_nxt;
    logic             kind_r, kind_nxt;
    logic             in_ready_r, busy_r;

    logic [3:0]       pred_s;
    logic [3:0]       next_mask_s;
    logic [CNT_W-1:0] cnt_inc_s;
    logic             accept_s;

    lu_ref_model u_ref (
        .a (a),
        .b (b),
        .p (pred_s)
    );

    assign next_mask_s = mask_r & ~(pred_s ^ {4{s_obs}});
    assign cnt_inc_s   = (cnt_r == CNT_MAX) ? cnt_r : cnt_r + CNT_ONE;
    // in_ready_r is high exactly when state_r is COLLECT.
    assign accept_s    = in_valid && in_ready_r && !start;

    // Next-state and next-output decision; start restarts from any state.
    always_comb begin
        state_nxt = state_r;
        mask_nxt  = mask_r;
        cnt_nxt   = cnt_r;
        op_nxt    = op_r;
        valid_nxt = valid_r;
        error_nxt = error_r;
        kind_nxt  = kind_r;
        if (start) begin
            state_nxt = ST_COLLECT;
            mask_nxt  = 4'b1111;
            cnt_nxt   = '0;
            valid_nxt = 1'b0;
            error_nxt = 1'b0;
        end else begin
            case (state_r)
                ST_COLLECT: begin
                    if (accept_s) begin
                        mask_nxt = next_mask_s;
                        cnt_nxt  = cnt_inc_s;
                        if (next_mask_s == 4'b0000) begin
                            state_nxt = ST_ERROR;
                            error_nxt = 1'b1;
                            kind_nxt  = ERR_CONTRA;
                        end else if (popcount4(next_mask_s) == 3'd1) begin
                            state_nxt = ST_DONE;
                            valid_nxt = 1'b1;
                            op_nxt    = onehot_index4(next_mask_s);
                        end else if (cnt_inc_s == CNT_MAX) begin
                            state_nxt = ST_ERROR;
                            error_nxt = 1'b1;
                            kind_nxt  = ERR_AMBIG;
                        end else begin
                            state_nxt = ST_COLLECT;
                        end
                    end else begin
                        state_nxt = ST_COLLECT;
                    end
                end
                default: state_nxt = state_r;
            endcase
        end
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= ST_IDLE;
            mask_r     <= 4'b1111;
            cnt_r      <= '0;
            op_r       <= 2'b00;
            valid_r    <= 1'b0;
            error_r    <= 1'b0;
            kind_r     <= 1'b0;
            in_ready_r <= 1'b0;
            busy_r     <= 1'b0;
        end else begin
            state_r    <= state_nxt;
            mask_r     <= mask_nxt;
            cnt_r      <= cnt_nxt;
            op_r       <= op_nxt;
            valid_r    <= valid_nxt;
            error_r    <= error_nxt;
            kind_r     <= kind_nxt;
            in_ready_r <= (state_nxt == ST_COLLECT);
            busy_r     <= (state_nxt == ST_COLLECT);
        end
    end

    assign in_ready     = in_ready_r;
    assign busy         = busy_r;
    assign id_valid     = valid_r;
    assign id_op        = op_r;
    assign id_error     = error_r;
    assign err_kind     = kind_r;
    assign cand_mask    = mask_r;
    assign sample_count = cnt_r;

endmodule

// File: tb/tb_lu_op_identifier.sv
// Table-driven bench for lu_op_identifier with an expectation queue.
module tb_lu_op_identifier;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       start = 1'b0;
    logic       in_valid = 1'b0;
    logic       a = 1'b0;
    logic       b = 1'b0;
    logic       s_obs = 1'b0;
    logic       in_ready, busy, id_valid, id_error, err_kind;
    logic [1:0] id_op;
    logic [3:0] cand_mask;
    logic [3:0] sample_count;

    logic       ra = 1'b0;
    logic       rb = 1'b0;
    logic [3:0] rp;

    int tests = 0;
    int fails = 0;

    typedef struct {
        logic       rst, start, in_valid, a, b, s;
        logic [14:0] exp;
    } vec_t;

    vec_t          vecs[$];
    logic [14:0]   sb[$];

    always #5 clk = ~clk;

    lu_op_identifier #(.MAX_SAMPLES(8), .CNT_W(4)) dut (
        .clk(clk), .rst(rst), .start(start), .in_valid(in_valid),
        .in_ready(in_ready), .a(a), .b(b), .s_obs(s_obs), .busy(busy),
        .id_valid(id_valid), .id_op(id_op), .id_error(id_error),
        .err_kind(err_kind), .cand_mask(cand_mask), .sample_count(sample_count)
    );

    lu_ref_model u_ref (.a(ra), .b(rb), .p(rp));

    // Expected outputs packed as {in_ready, busy, id_valid, id_error, err_kind, id_op, cand_mask, sample_count}.
    function automatic void add(input logic r, st, iv, ia, ib, is,
                                input logic ir, bz, v, e, k,
                                input logic [1:0] op, input logic [3:0] m,
                                input logic [3:0] c);
        vec_t t;
        t.rst = r; t.start = st; t.in_valid = iv; t.a = ia; t.b = ib; t.s = is;
        t.exp = {ir, bz, v, e, k, op, m, c};
        vecs.push_back(t);
    endfunction

    initial begin
        logic [3:0]  exp_p [4];
        logic [14:0] got, want;

        exp_p[0] = 4'b0101; exp_p[1] = 4'b1001; exp_p[2] = 4'b1001; exp_p[3] = 4'b1010;
        for (int i = 0; i < 4; i++) begin
            ra = i[1]; rb = i[0];
            #1;
            tests++;
            if (rp !== exp_p[i]) begin
                fails++;
                $display("FAIL ref_model a=%0b b=%0b: got %b expected %b", ra, rb, rp, exp_p[i]);
            end
        end

        //   rst st iv a b s | ir bz v e k  op     mask     cnt
        add(1, 0, 0, 0,0,0,  0, 0, 0,0,0, 2'b00, 4'b1111, 4'd0); // 0 reset
        add(0, 0, 1, 0,0,1,  0, 0, 0,0,0, 2'b00, 4'b1111, 4'd0); // 1 idle guard
        add(0, 1, 0, 0,0,0,  1, 1, 0,0,0, 2'b00, 4'b1111, 4'd0); // 2 start
        add(0, 0, 1, 0,0,1,  1, 1, 0,0,0, 2'b00, 4'b0101, 4'd1); // 3 NAND s1
        add(0, 0, 0, 1,1,0,  1, 1, 0,0,0, 2'b00, 4'b0101, 4'd1); // 4 no sample
        add(0, 0, 1, 0,1,1,  0, 0, 1,0,0, 2'b00, 4'b0001, 4'd2); // 5 NAND done
        add(0, 0, 1, 1,1,0,  0, 0, 1,0,0, 2'b00, 4'b0001, 4'd2); // 6 done guard
        add(0, 1, 0, 0,0,0,  1, 1, 0,0,0, 2'b00, 4'b1111, 4'd0); // 7 start
        add(0, 0, 1, 1,1,1,  1, 1, 0,0,0, 2'b00, 4'b1010, 4'd1); // 8 OR s1
        add(0, 0, 1, 0,1,1,  0, 0, 1,0,0, 2'b11, 4'b1000, 4'd2); // 9 OR done
        add(0, 1, 1, 0,0,1,  1, 1, 0,0,0, 2'b11, 4'b1111, 4'd0); // 10 start, sample dropped
        add(0, 0, 1, 0,0,1,  1, 1, 0,0,0, 2'b11, 4'b0101, 4'd1); // 11
        add(0, 1, 1, 0,0,0,  1, 1, 0,0,0, 2'b11, 4'b1111, 4'd0); // 12 restart mid-collect
        add(0, 0, 1, 0,0,1,  1, 1, 0,0,0, 2'b11, 4'b0101, 4'd1); // 13 contra s1
        add(0, 0, 1, 0,0,0,  0, 0, 0,1,0, 2'b11, 4'b0000, 4'd2); // 14 contradiction
        add(0, 0, 1, 1,1,1,  0, 0, 0,1,0, 2'b11, 4'b0000, 4'd2); // 15 error guard
        add(0, 1, 0, 0,0,0,  1, 1, 0,0,0, 2'b11, 4'b1111, 4'd0); // 16 start
        for (int i = 1; i < 8; i++)
            add(0, 0, 1, 0,1,1, 1, 1, 0,0,0, 2'b11, 4'b1001, 4'(i));
        add(0, 0, 1, 0,1,1,  0, 0, 0,1,1, 2'b11, 4'b1001, 4'd8); // 8th: ambiguous
        add(0, 0, 1, 0,1,1,  0, 0, 0,1,1, 2'b11, 4'b1001, 4'd8); // saturated, held
        add(0, 1, 0, 0,0,0,  1, 1, 0,0,1, 2'b11, 4'b1111, 4'd0); // start
        add(0, 0, 1, 1,1,1,  1, 1, 0,0,1, 2'b11, 4'b1010, 4'd1);
        add(1, 0, 1, 0,1,1,  0, 0, 0,0,0, 2'b00, 4'b1111, 4'd0); // rst mid-collect
        add(0, 1, 0, 0,0,0,  1, 1, 0,0,0, 2'b00, 4'b1111, 4'd0);
        add(1, 1, 1, 0,0,1,  0, 0, 0,0,0, 2'b00, 4'b1111, 4'd0); // rst beats start

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            rst = vecs[i].rst; start = vecs[i].start; in_valid = vecs[i].in_valid;
            a = vecs[i].a; b = vecs[i].b; s_obs = vecs[i].s;
            sb.push_back(vecs[i].exp);
            @(posedge clk);
            #1;
            got  = {in_ready, busy, id_valid, id_error, err_kind, id_op, cand_mask, sample_count};
            want = sb.pop_front();
            tests++;
            if (got !== want) begin
                fails++;
                $display("FAIL step %0d {rdy,busy,val,err,kind,op,mask,cnt}: got %b expected %b",
                         i, got, want);
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
